// File: rtl/oak_const_arbiter.sv
// Round-robin arbiter sharing the oak_foundation constant bank among N_REQ requesters.
// Each accepted request is answered on one registered, back-pressurable response channel.
module oak_const_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [63:0]          phi_i,
    input  logic [63:0]          pi_i,
    input  logic [63:0]          e_i,
    input  logic [63:0]          trinity_i,
    input  logic [31:0]          phoenix_id_i,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [3*N_REQ-1:0]   req_idx,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_err,
    output logic [CNT_W-1:0]     served_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cand;
    logic            found;
    logic            accept_en;
    logic            accept;
    logic [2:0]      idx_arr [N_REQ];
    logic [2:0]      sel_idx;
    logic [63:0]     sel_data;
    logic            sel_err;

    assign rsp_valid = (state == FULL);
    assign accept_en = !rsp_valid || rsp_ready;
    assign accept    = accept_en && found;
    assign req_ready = accept ? (N_REQ'(1) << winner) : '0;

    // Rotating priority search starting at rr_ptr
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ID_W'((32'(rr_ptr) + i) % N_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx_arr[k] = req_idx[3*k +: 3];
        end
    end

    assign sel_idx = idx_arr[winner];

    // Constant bank lookup; indices past the bank flag an error
    always_comb begin
        sel_data = 64'h0;
        sel_err  = 1'b0;
        case (sel_idx)
            3'd0:    sel_data = phi_i;
            3'd1:    sel_data = pi_i;
            3'd2:    sel_data = e_i;
            3'd3:    sel_data = trinity_i;
            3'd4:    sel_data = {32'h0, phoenix_id_i};
            default: sel_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // A handshake with a simultaneous accept stays FULL with no bubble
    always_comb begin
        state_nx = state;
        case (state)
            EMPTY:   if (accept) state_nx = FULL;
            FULL:    if (!accept && rsp_ready) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= 64'h0;
            rsp_id   <= '0;
            rsp_err  <= 1'b0;
            rr_ptr   <= '0;
        end else if (accept) begin
            rsp_data <= sel_data;
            rsp_id   <= winner;
            rsp_err  <= sel_err;
            rr_ptr   <= ID_W'((32'(winner) + 32'd1) % N_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served_cnt <= '0;
        end else if (rsp_valid && rsp_ready) begin
            served_cnt <= served_cnt + CNT_W'(1);
        end
    end

endmodule
